// File: rtl/fir_share_scheduler.sv
// Round-robin scheduler that time-shares one start/done FIR engine between
// NUM_CH sample sources, with one pending sample per channel and a job watchdog.
module fir_share_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [NUM_CH-1:0]          sample_strobe,
  input  logic [NUM_CH*WIDTH-1:0]    sample_in,
  input  logic                       clear_flags,
  output logic                       eng_start,
  output logic [WIDTH-1:0]           eng_sample,
  input  logic                       eng_done,
  input  logic [WIDTH-1:0]           eng_result,
  output logic                       out_valid,
  output logic [$clog2(NUM_CH)-1:0]  out_chan,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_err,
  output logic                       busy,
  output logic [NUM_CH-1:0]          overrun,
  output logic                       timeout_flag
);

  localparam int CW = $clog2(NUM_CH);
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_EMIT} state_t;

  state_t              state_q;
  logic [NUM_CH-1:0]   pend_q;
  logic [WIDTH-1:0]    slot_q [NUM_CH];
  logic [NUM_CH-1:0]   overrun_q;
  logic [CW-1:0]       last_grant_q;
  logic [CW-1:0]       chan_q;
  logic [TW-1:0]       timer_q;
  logic [WIDTH-1:0]    result_q;
  logic                err_q;
  logic                eng_start_q;
  logic [WIDTH-1:0]    eng_sample_q;
  logic                out_valid_q;
  logic [CW-1:0]       out_chan_q;
  logic [WIDTH-1:0]    out_data_q;
  logic                out_err_q;
  logic                busy_q;
  logic                timeout_q;

  logic                grant_vld;
  logic [CW-1:0]       grant_idx;
  logic [NUM_CH-1:0]   take_vec;

  // Round-robin search starting just above the last grant, wrapping around.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      int j;
      j = int'(last_grant_q) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!grant_vld && pend_q[j]) begin
        grant_vld = 1'b1;
        grant_idx = CW'(j);
      end
    end
  end

  always_comb begin
    take_vec = '0;
    if (state_q == S_IDLE && grant_vld) take_vec[grant_idx] = 1'b1;
  end

  // A slot being granted this cycle is free again, so a coincident strobe refills it.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (sample_strobe[i] && (!pend_q[i] || take_vec[i]))
        slot_q[i] <= sample_in[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pend_q    <= '0;
      overrun_q <= '0;
    end else begin
      pend_q    <= (pend_q & ~take_vec) | sample_strobe;
      overrun_q <= (overrun_q & ~{NUM_CH{clear_flags}}) |
                   (sample_strobe & pend_q & ~take_vec);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      last_grant_q <= CW'(NUM_CH - 1);
      chan_q       <= '0;
      timer_q      <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      eng_start_q  <= 1'b0;
      eng_sample_q <= '0;
      out_valid_q  <= 1'b0;
      out_chan_q   <= '0;
      out_data_q   <= '0;
      out_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      eng_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      if (clear_flags) timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_vld) begin
            chan_q       <= grant_idx;
            last_grant_q <= grant_idx;
            eng_sample_q <= slot_q[grant_idx];
            eng_start_q  <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (eng_done) begin
            result_q <= eng_result;
            err_q    <= 1'b0;
            state_q  <= S_EMIT;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            result_q  <= '0;
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= S_EMIT;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_EMIT: begin
          out_valid_q <= 1'b1;
          out_chan_q  <= chan_q;
          out_data_q  <= result_q;
          out_err_q   <= err_q;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign eng_start    = eng_start_q;
  assign eng_sample   = eng_sample_q;
  assign out_valid    = out_valid_q;
  assign out_chan     = out_chan_q;
  assign out_data     = out_data_q;
  assign out_err      = out_err_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;
  assign timeout_flag = timeout_q;

endmodule

// File: tb/tb_fir_share_scheduler.sv
// Bench for fir_share_scheduler: behavioural 33-cycle engine (result = sample*2),
// scoreboard queues for issued samples and tagged results.
module tb_fir_share_scheduler;

  localparam int NUM_CH  = 4;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 64;
  localparam int ENG_T   = 33;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [3:0]  sample_strobe = '0;
  logic [31:0] sample_in = '0;
  logic        clear_flags = 1'b0;
  logic        eng_start;
  logic [7:0]  eng_sample;
  logic        eng_done;
  logic [7:0]  eng_result;
  logic        out_valid;
  logic [1:0]  out_chan;
  logic [7:0]  out_data;
  logic        out_err;
  logic        busy;
  logic [3:0]  overrun;
  logic        timeout_flag;

  fir_share_scheduler #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .sample_strobe(sample_strobe),
    .sample_in(sample_in), .clear_flags(clear_flags), .eng_start(eng_start),
    .eng_sample(eng_sample), .eng_done(eng_done), .eng_result(eng_result),
    .out_valid(out_valid), .out_chan(out_chan), .out_data(out_data),
    .out_err(out_err), .busy(busy), .overrun(overrun), .timeout_flag(timeout_flag)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Engine model: answers ENG_T cycles after a start unless hung.
  int         eng_cnt = 0;
  logic [7:0] eng_res = '0;
  bit         eng_hang = 1'b0;
  always @(posedge clk_in) begin
    if (eng_start && !eng_hang) begin
      eng_cnt <= ENG_T;
      eng_res <= {eng_sample[6:0], 1'b0};
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
    end
  end
  assign eng_done   = (eng_cnt == 1);
  assign eng_result = eng_res;

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct packed {logic [1:0] ch; logic [7:0] d; logic e;} exp_t;
  logic [7:0] start_q[$];
  exp_t       out_q[$];
  int start_cyc = 0, done_cyc = 0, out_cyc = 0, stb_cyc = 0, n_out = 0;

  always @(negedge clk_in) begin
    logic [7:0] es;
    exp_t       eo;
    if (eng_done) done_cyc = cyc;
    if (eng_start) begin
      start_cyc = cyc;
      if (start_q.size() == 0) chk("unexpected_start", 1, 0);
      else begin
        es = start_q.pop_front();
        chk("eng_sample", eng_sample, es);
      end
    end
    if (out_valid) begin
      out_cyc = cyc;
      n_out++;
      if (out_q.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        eo = out_q.pop_front();
        chk("out_chan", out_chan, eo.ch);
        chk("out_data", out_data, eo.d);
        chk("out_err", out_err, eo.e);
      end
    end
  end

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  task automatic strobe(input logic [3:0] m, input logic [31:0] d);
    sample_strobe = m;
    sample_in     = d;
    stb_cyc       = cyc;
    tick();
    sample_strobe = '0;
  endtask

  task automatic do_reset();
    start_q.delete();
    out_q.delete();
    eng_hang = 1'b0;
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  task automatic wait_out(input int budget);
    int c;
    int n0;
    c = 0;
    n0 = n_out;
    while (n_out == n0 && c < budget) begin
      tick();
      c++;
    end
    if (n_out == n0) chk("wait_out_expired", 0, 1);
  endtask

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while ((start_q.size() != 0 || out_q.size() != 0 || busy !== 1'b0) && c < budget) begin
      tick();
      c++;
    end
    chk("drain_pending", start_q.size() + out_q.size(), 0);
    chk("drain_busy", busy, 0);
  endtask

  typedef struct {logic [1:0] ch; logic [7:0] smp; logic [7:0] res;} vec_t;
  vec_t tbl [5];

  initial begin
    int rst_cyc;
    tbl = '{'{2'd2, 8'h5A, 8'hB4}, '{2'd0, 8'h00, 8'h00}, '{2'd3, 8'hFF, 8'hFE},
            '{2'd1, 8'h80, 8'h00}, '{2'd2, 8'h7F, 8'hFE}};
    tick();
    do_reset();
    chk("reset_outputs", {eng_start, eng_sample, out_valid, out_chan, out_data,
                          out_err, busy, overrun, timeout_flag}, 0);

    // Single jobs: latency strobe->start and done->out_valid, busy clears.
    for (int i = 0; i < 5; i++) begin
      logic [31:0] d;
      d = '0;
      d[tbl[i].ch*8 +: 8] = tbl[i].smp;
      start_q.push_back(tbl[i].smp);
      out_q.push_back('{ch: tbl[i].ch, d: tbl[i].res, e: 1'b0});
      strobe(4'b0001 << tbl[i].ch, d);
      wait_out(200);
      chk("lat_strobe_start", start_cyc - stb_cyc, 2);
      chk("lat_done_out", out_cyc - done_cyc, 2);
      tick();
      chk("busy_after", busy, 0);
    end

    // Round-robin fairness.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      start_q.push_back(8'h10 + 8'(i));
      out_q.push_back('{ch: 2'(i), d: 8'h20 + 8'(2 * i), e: 1'b0});
    end
    strobe(4'b1111, 32'h13121110);
    wait_drain(400);
    start_q.push_back(8'h30);
    out_q.push_back('{ch: 2'd0, d: 8'h60, e: 1'b0});
    start_q.push_back(8'h33);
    out_q.push_back('{ch: 2'd3, d: 8'h66, e: 1'b0});
    strobe(4'b1001, 32'h33000030);
    wait_drain(200);

    // Overrun while ch0 runs; ch1 keeps its first sample.
    do_reset();
    start_q.push_back(8'h11);
    out_q.push_back('{ch: 2'd0, d: 8'h22, e: 1'b0});
    start_q.push_back(8'h22);
    out_q.push_back('{ch: 2'd1, d: 8'h44, e: 1'b0});
    strobe(4'b0011, 32'h00002211);
    repeat (4) tick();
    strobe(4'b0010, 32'h00003300);
    chk("overrun_set", overrun, 4'b0010);
    wait_drain(200);
    chk("overrun_sticky", overrun, 4'b0010);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    chk("overrun_cleared", overrun, 4'b0000);

    // Strobe on the same cycle the channel is granted.
    do_reset();
    start_q.push_back(8'h66);
    out_q.push_back('{ch: 2'd0, d: 8'hCC, e: 1'b0});
    start_q.push_back(8'h67);
    out_q.push_back('{ch: 2'd0, d: 8'hCE, e: 1'b0});
    strobe(4'b0001, 32'h00000066);
    strobe(4'b0001, 32'h00000067);
    chk("collision_no_overrun", overrun, 4'b0000);
    wait_drain(200);

    // Watchdog abort, then the next pending channel served normally.
    do_reset();
    eng_hang = 1'b1;
    start_q.push_back(8'h44);
    out_q.push_back('{ch: 2'd2, d: 8'h00, e: 1'b1});
    start_q.push_back(8'h55);
    out_q.push_back('{ch: 2'd3, d: 8'hAA, e: 1'b0});
    strobe(4'b0100, 32'h00440000);
    repeat (3) tick();
    strobe(4'b1000, 32'h55000000);
    wait_out(200);
    eng_hang = 1'b0;
    chk("timeout_wait_len", out_cyc - start_cyc, TIMEOUT + 2);
    chk("timeout_flag_set", timeout_flag, 1);
    wait_drain(200);
    chk("timeout_flag_sticky", timeout_flag, 1);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    chk("timeout_flag_cleared", timeout_flag, 0);

    // Reset during WAIT drops the job and the pending ch2 sample.
    do_reset();
    start_q.push_back(8'h21);
    strobe(4'b0110, 32'h00422100);
    repeat (6) tick();
    chk("midjob_started", start_q.size(), 0);
    rst_in = 1'b1;
    rst_cyc = cyc;
    tick();
    rst_in = 1'b0;
    repeat (45) tick();
    chk("late_done_seen", done_cyc > rst_cyc, 1);
    chk("midjob_outputs", {eng_start, eng_sample, out_valid, out_chan, out_data,
                           out_err, busy, overrun, timeout_flag}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
